// File: rtl/wb_frame_gate.sv
// Frame-synchronised capture gate between the camera stream FIFO and the wishbone stream writer.
// Captures NFRM frames (or runs continuously) with decimation, start-of-frame marking and drop counting.
module wb_frame_gate #(
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input  logic          wb_clk_i,
  input  logic          wb_rstn_i,
  input  logic [4:0]    wb_adr_i,
  input  logic [31:0]   wb_dat_i,
  input  logic [3:0]    wb_sel_i,
  input  logic          wb_we_i,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  output logic [31:0]   wb_dat_o,
  output logic          wb_ack_o,
  output logic          wb_err_o,
  input  logic          frame_start_i,
  input  logic [DW-1:0] s_data_i,
  input  logic          s_valid_i,
  output logic          s_ready_o,
  output logic [DW-1:0] m_data_o,
  output logic          m_sof_o,
  output logic          m_valid_o,
  input  logic          m_ready_i,
  output logic          irq_o
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_CAP, S_DONE} state_e;

  state_e           state_q, state_d;
  logic             fs_q, fs_d;
  logic             ack_q, ack_d;
  logic [31:0]      dat_q, dat_d;
  logic             cont_q, cont_d;
  logic             irq_en_q, irq_en_d;
  logic [CNT_W-1:0] nfrm_q, nfrm_d;
  logic [CNT_W-1:0] skip_q, skip_d;
  logic [CNT_W-1:0] frames_q, frames_d;
  logic [CNT_W-1:0] skipcnt_q, skipcnt_d;
  logic [CNT_W-1:0] drops_q, drops_d;
  logic             done_q, done_d;
  logic             sof_pend_q, sof_pend_d;
  logic [DW-1:0]    m_data_q, m_data_d;
  logic             m_sof_q, m_sof_d;
  logic             m_valid_q, m_valid_d;

  logic             req, wr, fe, busy;
  logic [2:0]       reg_sel;
  logic             wr_ctrl, wr_nfrm, wr_skip, wr_stat;
  logic             start_ok, abort, done_clr;
  logic             skip_hit, cap_end;
  logic [CNT_W-1:0] nfrm_eff, frames_inc;
  logic             frame_begin, gate_open, load, drop;
  logic [31:0]      rdata;
  logic [15:0]      frames16;
  logic             unused_bits;

  assign req      = wb_cyc_i & wb_stb_i & ~ack_q;
  assign wr       = req & wb_we_i & (wb_sel_i == 4'hF);
  assign reg_sel  = wb_adr_i[4:2];
  assign wr_ctrl  = wr & (reg_sel == 3'd0);
  assign wr_nfrm  = wr & (reg_sel == 3'd1);
  assign wr_skip  = wr & (reg_sel == 3'd2);
  assign wr_stat  = wr & (reg_sel == 3'd3);
  assign abort    = wr_ctrl & wb_dat_i[1];
  assign start_ok = wr_ctrl & wb_dat_i[0] & ~wb_dat_i[1] & (state_q == S_IDLE);
  assign done_clr = wr_stat & wb_dat_i[1];

  assign fe         = frame_start_i & ~fs_q;
  assign busy       = (state_q == S_ARM) | (state_q == S_CAP);
  assign nfrm_eff   = (nfrm_q == '0) ? CNT_W'(1) : nfrm_q;
  assign frames_inc = frames_q + CNT_W'(1);
  assign skip_hit   = (skipcnt_q >= skip_q);
  assign cap_end    = (frames_inc == nfrm_eff) & ~cont_q;
  assign frames16   = 16'(frames_q);
  assign unused_bits = ^{wb_adr_i[1:0], wb_dat_i};

  always_comb begin
    rdata = '0;
    case (reg_sel)
      3'd0:    rdata = {28'd0, irq_en_q, cont_q, 2'b00};
      3'd1:    rdata = 32'(nfrm_q);
      3'd2:    rdata = 32'(skip_q);
      3'd3:    rdata = {frames16, 14'd0, done_q, busy};
      3'd4:    rdata = 32'(drops_q);
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  // ABORT overrides everything, including a coincident frame edge.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (start_ok) state_d = S_ARM;
        S_ARM:  if (fe && skip_hit) state_d = S_CAP;
        S_CAP: begin
          if (fe && cap_end)              state_d = S_DONE;
          else if (fe && skip_q != '0)    state_d = S_ARM;
        end
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    frame_begin = 1'b0;
    gate_open   = 1'b0;
    if (!abort && fe) begin
      frame_begin = ((state_q == S_ARM) && skip_hit) ||
                    ((state_q == S_CAP) && !cap_end && (skip_q == '0));
    end
    gate_open = frame_begin || ((state_q == S_CAP) && !fe);
    load = gate_open & s_valid_i & (~m_valid_q | m_ready_i);
    drop = gate_open & s_valid_i & ~load;
  end

  always_comb begin
    fs_d       = frame_start_i;
    ack_d      = req;
    dat_d      = (req && !wb_we_i) ? rdata : 32'd0;
    cont_d     = cont_q;
    irq_en_d   = irq_en_q;
    nfrm_d     = nfrm_q;
    skip_d     = skip_q;
    frames_d   = frames_q;
    skipcnt_d  = skipcnt_q;
    drops_d    = drops_q;
    done_d     = done_q;
    sof_pend_d = sof_pend_q;
    m_data_d   = m_data_q;
    m_sof_d    = m_sof_q;
    m_valid_d  = m_valid_q;

    if (wr_ctrl) begin
      cont_d   = wb_dat_i[2];
      irq_en_d = wb_dat_i[3];
    end
    if (wr_nfrm) nfrm_d = wb_dat_i[CNT_W-1:0];
    if (wr_skip) skip_d = wb_dat_i[CNT_W-1:0];

    // Arming preloads the skip counter as satisfied so the first frame after START is captured.
    if (start_ok) begin
      frames_d  = '0;
      skipcnt_d = skip_q;
      drops_d   = '0;
    end else if (!abort && fe) begin
      if (state_q == S_ARM) begin
        skipcnt_d = skip_hit ? '0 : skipcnt_q + CNT_W'(1);
      end else if (state_q == S_CAP) begin
        frames_d = frames_inc;
        if (!cap_end && skip_q != '0) skipcnt_d = CNT_W'(1);
      end
    end
    if (!start_ok && drop && drops_q != '1) drops_d = drops_q + CNT_W'(1);

    if (start_ok)                            done_d = 1'b0;
    else if (state_q == S_DONE && !abort)    done_d = 1'b1;
    else if (done_clr)                       done_d = 1'b0;

    if (start_ok || load)                           sof_pend_d = 1'b0;
    else if (frame_begin)                           sof_pend_d = 1'b1;
    else if (state_q == S_CAP && fe)                sof_pend_d = 1'b0;

    if (load) begin
      m_data_d  = s_data_i;
      m_sof_d   = sof_pend_q | frame_begin;
      m_valid_d = 1'b1;
    end else if (m_ready_i) begin
      m_sof_d   = 1'b0;
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      fs_q       <= 1'b0;
      ack_q      <= 1'b0;
      dat_q      <= '0;
      cont_q     <= 1'b0;
      irq_en_q   <= 1'b0;
      nfrm_q     <= '0;
      skip_q     <= '0;
      frames_q   <= '0;
      skipcnt_q  <= '0;
      drops_q    <= '0;
      done_q     <= 1'b0;
      sof_pend_q <= 1'b0;
      m_data_q   <= '0;
      m_sof_q    <= 1'b0;
      m_valid_q  <= 1'b0;
    end else begin
      fs_q       <= fs_d;
      ack_q      <= ack_d;
      dat_q      <= dat_d;
      cont_q     <= cont_d;
      irq_en_q   <= irq_en_d;
      nfrm_q     <= nfrm_d;
      skip_q     <= skip_d;
      frames_q   <= frames_d;
      skipcnt_q  <= skipcnt_d;
      drops_q    <= drops_d;
      done_q     <= done_d;
      sof_pend_q <= sof_pend_d;
      m_data_q   <= m_data_d;
      m_sof_q    <= m_sof_d;
      m_valid_q  <= m_valid_d;
    end
  end

  assign wb_dat_o  = dat_q;
  assign wb_ack_o  = ack_q;
  assign wb_err_o  = 1'b0;
  assign s_ready_o = 1'b1;
  assign m_data_o  = m_data_q;
  assign m_sof_o   = m_sof_q;
  assign m_valid_o = m_valid_q;
  assign irq_o     = done_q & irq_en_q;

endmodule

// File: tb/tb_wb_frame_gate.sv
// Directed bench for wb_frame_gate: register programming, frame capture, decimation,
// backpressure drops, abort, continuous mode and asynchronous reset.
module tb_wb_frame_gate;
  localparam int DW = 32;

  localparam logic [4:0] A_CTRL  = 5'h00;
  localparam logic [4:0] A_NFRM  = 5'h04;
  localparam logic [4:0] A_SKIP  = 5'h08;
  localparam logic [4:0] A_STAT  = 5'h0C;
  localparam logic [4:0] A_DROPS = 5'h10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [4:0]    wb_adr = '0;
  logic [31:0]   wb_wdat = '0;
  logic [3:0]    wb_sel = '0;
  logic          wb_we = 1'b0;
  logic          wb_cyc = 1'b0;
  logic          wb_stb = 1'b0;
  logic [31:0]   wb_rdat;
  logic          wb_ack;
  logic          wb_err;
  logic          frame_start = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] m_data;
  logic          m_sof;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic          irq;

  logic [DW:0]   sb[$];
  logic [DW:0]   exp_beat;
  logic [31:0]   rd;
  int            vectors = 0;
  int            miscompares = 0;
  int            out_count = 0;

  always #5 clk = ~clk;

  wb_frame_gate #(.DW(DW), .CNT_W(16)) dut (
    .wb_clk_i(clk), .wb_rstn_i(rst_n),
    .wb_adr_i(wb_adr), .wb_dat_i(wb_wdat), .wb_sel_i(wb_sel), .wb_we_i(wb_we),
    .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_dat_o(wb_rdat), .wb_ack_o(wb_ack),
    .wb_err_o(wb_err), .frame_start_i(frame_start), .s_data_i(s_data),
    .s_valid_i(s_valid), .s_ready_o(s_ready), .m_data_o(m_data), .m_sof_o(m_sof),
    .m_valid_o(m_valid), .m_ready_i(m_ready), .irq_o(irq)
  );

  // Each output handshake is popped against the scoreboard on the falling edge.
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      out_count++;
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL unexpected_beat: got sof=%0b data=%h, expected no beat", m_sof, m_data);
      end else begin
        exp_beat = sb.pop_front();
        assert ({m_sof, m_data} === exp_beat) else begin
          miscompares++;
          $error("[TB] FAIL beat: got sof=%0b data=%h, expected sof=%0b data=%h",
                 m_sof, m_data, exp_beat[DW], exp_beat[DW-1:0]);
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic wbAccess(input logic [4:0] adr, input logic we, input logic [31:0] wdat,
                          output logic [31:0] rdat);
    int n;
    @(posedge clk); #1;
    wb_adr = adr; wb_we = we; wb_wdat = wdat; wb_sel = 4'hF; wb_cyc = 1'b1; wb_stb = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!wb_ack && n < 8);
    if (!wb_ack) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL ack_timeout: got no ack, expected ack within 8 cycles");
    end
    rdat = wb_rdat;
    @(posedge clk); #1;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
  endtask

  task automatic wbWrite(input logic [4:0] adr, input logic [31:0] wdat);
    logic [31:0] dummy;
    wbAccess(adr, 1'b1, wdat, dummy);
  endtask

  task automatic wbRead(input logic [4:0] adr, output logic [31:0] rdat);
    wbAccess(adr, 1'b0, 32'd0, rdat);
  endtask

  // Drives one frame; when capture is set the expected beats (sof on beat 0) go to the scoreboard.
  task automatic applyStimulus(input int nbeats, input bit capture, input int base);
    logic [DW-1:0] d;
    for (int i = 0; i < nbeats; i++) begin
      @(posedge clk); #1;
      d = DW'(base + i);
      frame_start = (i < 2);
      s_valid = 1'b1;
      s_data = d;
      if (capture) sb.push_back({(i == 0), d});
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    frame_start = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic pulseFrame();
    @(posedge clk); #1;
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    checkOutput("drain_pending", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_m_valid", 32'(m_valid), 32'd0);
    checkOutput("rst_s_ready", 32'(s_ready), 32'd1);
    rst_n = 1'b1;
    #1;
    checkOutput("rst_irq_ack_err", {29'd0, irq, wb_ack, wb_err}, 32'd0);
    wbRead(A_STAT, rd);
    checkOutput("rst_stat", rd, 32'd0);

    $display("[TB] two frames, no skip");
    out_count = 0;
    wbWrite(A_NFRM, 32'd2);
    wbWrite(A_SKIP, 32'd0);
    wbWrite(A_CTRL, 32'h9);
    wbRead(A_STAT, rd);
    checkOutput("t1_busy", rd, 32'h0000_0001);
    applyStimulus(8, 1'b1, 32'h100);
    applyStimulus(8, 1'b1, 32'h200);
    applyStimulus(4, 1'b0, 32'h300);
    waitDrain();
    checkOutput("t1_beats", 32'(out_count), 32'd16);
    checkOutput("t1_irq", 32'(irq), 32'd1);
    wbRead(A_STAT, rd);
    checkOutput("t1_stat", rd, 32'h0002_0002);
    wbWrite(A_STAT, 32'h2);
    #1;
    checkOutput("t1_irq_cleared", 32'(irq), 32'd0);

    $display("[TB] decimation SKIP=2");
    out_count = 0;
    wbWrite(A_SKIP, 32'd2);
    wbWrite(A_CTRL, 32'h1);
    applyStimulus(4, 1'b1, 32'h400);
    applyStimulus(4, 1'b0, 32'h500);
    applyStimulus(4, 1'b0, 32'h600);
    applyStimulus(4, 1'b1, 32'h700);
    applyStimulus(4, 1'b0, 32'h800);
    waitDrain();
    checkOutput("t2_beats", 32'(out_count), 32'd8);
    wbRead(A_STAT, rd);
    checkOutput("t2_stat", rd, 32'h0002_0002);

    $display("[TB] backpressure drops");
    out_count = 0;
    wbWrite(A_NFRM, 32'd1);
    wbWrite(A_SKIP, 32'd0);
    wbWrite(A_CTRL, 32'h1);
    m_ready = 1'b0;
    sb.push_back({1'b1, 32'h900});
    applyStimulus(10, 1'b0, 32'h900);
    applyStimulus(3, 1'b0, 32'hA00);
    wbRead(A_DROPS, rd);
    checkOutput("t3_drops", rd, 32'd9);
    checkOutput("t3_held", {m_sof, m_valid, 30'd0}, 32'hC000_0000);
    m_ready = 1'b1;
    waitDrain();
    checkOutput("t3_beats", 32'(out_count), 32'd1);

    $display("[TB] abort mid-frame");
    out_count = 0;
    wbWrite(A_NFRM, 32'd2);
    wbWrite(A_CTRL, 32'h9);
    wbRead(A_STAT, rd);
    checkOutput("t4_busy", rd, 32'h0000_0001);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      frame_start = (i < 2);
      s_valid = 1'b1;
      s_data = DW'(32'hB00 + i);
      if (i <= 4) sb.push_back({(i == 0), DW'(32'hB00 + i)});
      if (i == 4) begin
        wb_adr = A_CTRL; wb_we = 1'b1; wb_wdat = 32'hA; wb_sel = 4'hF;
        wb_cyc = 1'b1; wb_stb = 1'b1;
      end
      if (i == 5) begin
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
      end
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    frame_start = 1'b0;
    waitDrain();
    checkOutput("t4_beats", 32'(out_count), 32'd5);
    checkOutput("t4_irq", 32'(irq), 32'd0);
    wbRead(A_STAT, rd);
    checkOutput("t4_stat", rd, 32'd0);

    $display("[TB] continuous mode and async reset");
    out_count = 0;
    wbWrite(A_NFRM, 32'd1);
    wbWrite(A_CTRL, 32'h5);
    applyStimulus(4, 1'b1, 32'hC00);
    applyStimulus(4, 1'b1, 32'hD00);
    applyStimulus(4, 1'b1, 32'hE00);
    pulseFrame();
    waitDrain();
    checkOutput("t5_beats", 32'(out_count), 32'd12);
    wbRead(A_STAT, rd);
    checkOutput("t5_stat", rd, 32'h0003_0001);
    @(posedge clk); #1;
    s_valid = 1'b1;
    s_data = DW'(32'hF00);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t5_rst_outputs", {28'd0, m_valid, m_sof, irq, wb_ack}, 32'd0);
    checkOutput("t5_rst_data", m_data, 32'd0);
    s_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wbRead(A_STAT, rd);
    checkOutput("t5_stat_after_rst", rd, 32'd0);
    wbRead(A_CTRL, rd);
    checkOutput("t5_ctrl_after_rst", rd, 32'd0);
    wbRead(A_NFRM, rd);
    checkOutput("t5_nfrm_after_rst", rd, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("t5_no_output", 32'(out_count), 32'd12);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
